// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG register bridge: instruction codes,
// per-instruction data-register lengths and the bus FSM state encoding.
// No ports; imported by jtag_dr_shifter and jtag_reg_bridge.
package jtag_pkg;

  typedef enum logic [2:0] {
    IR_BYPASS = 3'd0,
    IR_IDCODE = 3'd1,
    IR_ADDR   = 3'd2,
    IR_WRITE  = 3'd3,
    IR_READ   = 3'd4,
    IR_STATUS = 3'd5
  } ir_code_t;

  localparam int unsigned DR_LEN_BYPASS = 1;
  localparam int unsigned DR_LEN_IDCODE = 32;
  localparam int unsigned DR_LEN_ADDR   = 8;
  localparam int unsigned DR_LEN_WRITE  = 16;
  localparam int unsigned DR_LEN_READ   = 17;
  localparam int unsigned DR_LEN_STATUS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_PEND = 2'd1,
    ST_RD_PEND = 2'd2
  } bus_state_t;

  // Bit position that receives tdi during a shift; unknown codes act as BYPASS.
  function automatic logic [4:0] dr_msb(input logic [2:0] ir);
    case (ir)
      IR_IDCODE: dr_msb = 5'(DR_LEN_IDCODE - 1);
      IR_ADDR:   dr_msb = 5'(DR_LEN_ADDR - 1);
      IR_WRITE:  dr_msb = 5'(DR_LEN_WRITE - 1);
      IR_READ:   dr_msb = 5'(DR_LEN_READ - 1);
      IR_STATUS: dr_msb = 5'(DR_LEN_STATUS - 1);
      default:   dr_msb = 5'(DR_LEN_BYPASS - 1);
    endcase
  endfunction

endpackage

// File: rtl/jtag_dr_shifter.sv
// Purpose: 32-bit data-register shifter with per-instruction capture and length.
// Latency: capture/shift take effect on the tck edge that samples the strobe; tdo is combinational from sr[0].
// Backpressure: none; the virtual TAP strobes are always accepted.
// Ports: tck/rst clock+sync reset; tdi/tdo serial data; ir current instruction;
//        cdr/sdr capture/shift strobes; addr..status capture sources; upd_dat low 16 bits of SR for update.
module jtag_dr_shifter
  import jtag_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h4B340001
) (
  input  logic        tck,
  input  logic        rst,
  input  logic        tdi,
  input  logic [2:0]  ir,
  input  logic        cdr,
  input  logic        sdr,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  input  logic        rd_valid,
  input  logic [15:0] rd_hold,
  input  logic [7:0]  status,
  output logic [15:0] upd_dat,
  output logic        tdo
);

  logic [31:0] sr;
  logic [31:0] cap_val;
  logic [31:0] shift_val;

  always_comb begin
    cap_val = '0;
    case (ir)
      IR_IDCODE: cap_val = ID_VALUE;
      IR_ADDR:   cap_val = {24'b0, addr};
      IR_WRITE:  cap_val = {16'b0, wdata};
      IR_READ:   cap_val = {15'b0, rd_valid, rd_hold};
      IR_STATUS: cap_val = {24'b0, status};
      default:   cap_val = '0;
    endcase
  end

  // Right shift; tdi enters at the top of the active register length so
  // after exactly 'length' shifts the scanned-in word sits at sr[len-1:0].
  always_comb begin
    shift_val = sr >> 1;
    shift_val[dr_msb(ir)] = tdi;
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      sr <= '0;
    end else if (cdr) begin
      sr <= cap_val;
    end else if (sdr) begin
      sr <= shift_val;
    end
  end

  assign tdo     = sr[0];
  assign upd_dat = sr[15:0];

endmodule

// File: rtl/jtag_reg_bridge.sv
// Purpose: virtual-JTAG to 8-bit-address/16-bit-data register bus bridge.
// Latency: bus request is registered, asserted the cycle after UDR/UIR; released the cycle after ack or timeout.
// Backpressure: one access in flight; requests while busy are dropped and flag overrun_err.
// Ports: tck/rst clock+sync reset; tdi/tdo, ir_in/ir_out, vs_* virtual TAP interface;
//        bus_addr/bus_wdata/bus_wr/bus_rd request, bus_ack/bus_rdata completion.
module jtag_reg_bridge
  import jtag_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h4B340001,
  parameter int          TIMEOUT  = 255
) (
  input  logic        tck,
  input  logic        rst,
  input  logic        tdi,
  output logic        tdo,
  input  logic [2:0]  ir_in,
  output logic [2:0]  ir_out,
  input  logic        vs_cdr,
  input  logic        vs_sdr,
  input  logic        vs_udr,
  input  logic        vs_cir,
  input  logic        vs_uir,
  output logic [7:0]  bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  bus_state_t    state;
  logic [CW-1:0] cnt;
  logic [7:0]    addr;
  logic [7:0]    addr_nxt;
  logic          addr_nxt_vld;
  logic [15:0]   wdata;
  logic [15:0]   rd_hold;
  logic          rd_valid;
  logic          timeout_err;
  logic          overrun_err;
  logic          busy;
  logic [7:0]    status;
  logic [15:0]   upd_dat;
  logic          wr_req;
  logic          rd_req;
  logic          addr_upd;
  logic          stat_upd;
  logic          tmo_hit;

  assign busy     = (state != ST_IDLE);
  assign status   = {4'b0, timeout_err, overrun_err, rd_valid, busy};
  assign wr_req   = vs_udr && (ir_in == IR_WRITE);
  assign rd_req   = vs_uir && (ir_in == IR_READ);
  assign addr_upd = vs_udr && (ir_in == IR_ADDR);
  assign stat_upd = vs_udr && (ir_in == IR_STATUS);
  // cnt counts completed pending cycles; this cycle is the TIMEOUT-th one.
  assign tmo_hit  = (cnt == TMO - 1'b1);

  assign bus_addr  = addr;
  assign bus_wdata = wdata;

  jtag_dr_shifter #(
    .ID_VALUE (ID_VALUE)
  ) u_shifter (
    .tck      (tck),
    .rst      (rst),
    .tdi      (tdi),
    .ir       (ir_in),
    .cdr      (vs_cdr),
    .sdr      (vs_sdr),
    .addr     (addr),
    .wdata    (wdata),
    .rd_valid (rd_valid),
    .rd_hold  (rd_hold),
    .status   (status),
    .upd_dat  (upd_dat),
    .tdo      (tdo)
  );

  always_ff @(posedge tck) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      addr         <= '0;
      addr_nxt     <= '0;
      addr_nxt_vld <= 1'b0;
      wdata        <= '0;
      rd_hold      <= '0;
      rd_valid     <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
      ir_out       <= '0;
      bus_wr       <= 1'b0;
      bus_rd       <= 1'b0;
    end else begin
      if (vs_cir) begin
        ir_out <= {timeout_err | overrun_err, rd_valid, busy};
      end

      // Write-one-to-clear; a flag set later in this block still wins.
      if (stat_upd) begin
        if (upd_dat[3]) timeout_err <= 1'b0;
        if (upd_dat[2]) overrun_err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (addr_upd) addr <= upd_dat[7:0];
          if (wr_req) begin
            wdata  <= upd_dat;
            state  <= ST_WR_PEND;
            bus_wr <= 1'b1;
          end else if (rd_req) begin
            rd_valid <= 1'b0;
            state    <= ST_RD_PEND;
            bus_rd   <= 1'b1;
          end
        end

        default: begin
          // wdata is left untouched so the bus sees a stable request.
          if (wr_req || rd_req) overrun_err <= 1'b1;

          if (bus_ack || tmo_hit) begin
            state        <= ST_IDLE;
            bus_wr       <= 1'b0;
            bus_rd       <= 1'b0;
            cnt          <= '0;
            addr_nxt_vld <= 1'b0;
            // A user-written address deferred during the access overrides the increment.
            if (addr_upd)          addr <= upd_dat[7:0];
            else if (addr_nxt_vld) addr <= addr_nxt;
            else if (bus_ack)      addr <= addr + 8'd1;
            if (bus_ack && state == ST_RD_PEND) begin
              rd_hold  <= bus_rdata;
              rd_valid <= 1'b1;
            end
            if (!bus_ack) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (addr_upd) begin
              addr_nxt     <= upd_dat[7:0];
              addr_nxt_vld <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Directed bench for jtag_reg_bridge: scans through the virtual TAP strobes
// and checks serial data, bus requests and status against hand-computed values.
module tb_jtag_reg_bridge;

  logic        tck = 1'b0;
  logic        rst = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [2:0]  ir_in = 3'd0;
  logic [2:0]  ir_out;
  logic        vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0, vs_cir = 1'b0, vs_uir = 1'b0;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_wr, bus_rd;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_starts = 0;
  logic wr_d = 1'b0;
  logic [31:0] sout;
  int wr_base;

  always #5 tck = ~tck;

  jtag_reg_bridge dut (
    .tck       (tck),
    .rst       (rst),
    .tdi       (tdi),
    .tdo       (tdo),
    .ir_in     (ir_in),
    .ir_out    (ir_out),
    .vs_cdr    (vs_cdr),
    .vs_sdr    (vs_sdr),
    .vs_udr    (vs_udr),
    .vs_cir    (vs_cir),
    .vs_uir    (vs_uir),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  // Count distinct write transactions seen on the bus.
  always @(posedge tck) begin
    wr_d <= bus_wr;
    if (bus_wr && !wr_d) wr_starts <= wr_starts + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic set_ir(input logic [2:0] code);
    ir_in  = code;
    vs_uir = 1'b1;
    tick();
    vs_uir = 1'b0;
  endtask

  task automatic cir();
    vs_cir = 1'b1;
    tick();
    vs_cir = 1'b0;
  endtask

  // CDR, len shifts (tdo sampled before each shift), then UDR.
  task automatic scan_dr(input int len, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    vs_cdr = 1'b1;
    tick();
    vs_cdr = 1'b0;
    for (int i = 0; i < len; i++) begin
      tdi     = din[i];
      dout[i] = tdo;
      vs_sdr  = 1'b1;
      tick();
      vs_sdr  = 1'b0;
    end
    tdi    = 1'b0;
    vs_udr = 1'b1;
    tick();
    vs_udr = 1'b0;
  endtask

  task automatic ack(input logic [15:0] rdata);
    bus_rdata = rdata;
    bus_ack   = 1'b1;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 16'h0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_tdo", {31'b0, tdo}, 32'h0);
    chk("rst_ir_out", {29'b0, ir_out}, 32'h0);
    chk("rst_bus_req", {30'b0, bus_wr, bus_rd}, 32'h0);
    chk("rst_bus_addr", {24'b0, bus_addr}, 32'h0);
    chk("rst_bus_wdata", {16'b0, bus_wdata}, 32'h0);

    // IDCODE
    set_ir(3'd1);
    scan_dr(32, 32'h0, sout);
    chk("idcode", sout, 32'h4B340001);

    // BYPASS and unused code 6 act as a one-bit register capturing 0
    set_ir(3'd0);
    scan_dr(2, 32'h3, sout);
    chk("bypass", sout, 32'h2);
    set_ir(3'd6);
    scan_dr(2, 32'h3, sout);
    chk("bypass_code6", sout, 32'h2);

    // ADDR 0x10 then WRITE 0xBEEF
    set_ir(3'd2);
    scan_dr(8, 32'h10, sout);
    chk("addr_capture_reset_val", sout, 32'h0);
    chk("addr_latched", {24'b0, bus_addr}, 32'h10);
    wr_base = wr_starts;
    set_ir(3'd3);
    scan_dr(16, 32'hBEEF, sout);
    chk("wr_req_high", {31'b0, bus_wr}, 32'h1);
    chk("wr_addr", {24'b0, bus_addr}, 32'h10);
    chk("wr_wdata", {16'b0, bus_wdata}, 32'hBEEF);
    tick();
    tick();
    chk("wr_held", {31'b0, bus_wr}, 32'h1);
    ack(16'h0);
    chk("wr_done", {31'b0, bus_wr}, 32'h0);
    chk("wr_addr_inc", {24'b0, bus_addr}, 32'h11);

    // Timeout: bus_wr held for 255 cycles, then dropped
    set_ir(3'd3);
    scan_dr(16, 32'h1111, sout);
    chk("tmo_start", {31'b0, bus_wr}, 32'h1);
    repeat (254) tick();
    chk("tmo_before_limit", {31'b0, bus_wr}, 32'h1);
    tick();
    chk("tmo_dropped", {31'b0, bus_wr}, 32'h0);
    chk("tmo_addr_kept", {24'b0, bus_addr}, 32'h11);
    set_ir(3'd5);
    scan_dr(8, 32'h08, sout);
    chk("status_tmo", sout, 32'h08);
    scan_dr(8, 32'h00, sout);
    chk("status_cleared", sout, 32'h00);

    // READ at 0x20
    set_ir(3'd2);
    scan_dr(8, 32'h20, sout);
    set_ir(3'd4);
    chk("rd_req_high", {31'b0, bus_rd}, 32'h1);
    chk("rd_addr", {24'b0, bus_addr}, 32'h20);
    tick();
    ack(16'h1234);
    chk("rd_done", {31'b0, bus_rd}, 32'h0);
    chk("rd_addr_inc", {24'b0, bus_addr}, 32'h21);
    scan_dr(17, 32'h0, sout);
    chk("read_dr", sout, 32'h11234);

    // Overrun plus deferred ADDR update while a write is pending
    set_ir(3'd2);
    scan_dr(8, 32'h30, sout);
    wr_base = wr_starts;
    set_ir(3'd3);
    scan_dr(16, 32'hAAAA, sout);
    scan_dr(16, 32'h5555, sout);
    chk("ovr_wdata_stable", {16'b0, bus_wdata}, 32'hAAAA);
    chk("ovr_still_pending", {31'b0, bus_wr}, 32'h1);
    set_ir(3'd2);
    scan_dr(8, 32'h40, sout);
    chk("addr_deferred", {24'b0, bus_addr}, 32'h30);
    ack(16'h0);
    chk("ovr_done", {31'b0, bus_wr}, 32'h0);
    chk("addr_applied", {24'b0, bus_addr}, 32'h40);
    chk("ovr_single_txn", wr_starts - wr_base, 32'd1);
    cir();
    chk("ovr_ir_out", {29'b0, ir_out}, 32'h6);

    // Reset during RD_PEND, then a late ack
    set_ir(3'd4);
    chk("rd2_pending", {31'b0, bus_rd}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack(16'hFFFF);
    chk("rst2_bus_req", {30'b0, bus_wr, bus_rd}, 32'h0);
    chk("rst2_bus_addr", {24'b0, bus_addr}, 32'h0);
    chk("rst2_bus_wdata", {16'b0, bus_wdata}, 32'h0);
    chk("rst2_ir_out", {29'b0, ir_out}, 32'h0);
    chk("rst2_tdo", {31'b0, tdo}, 32'h0);
    set_ir(3'd5);
    scan_dr(8, 32'h0, sout);
    chk("rst2_status", sout, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_reg_bridge.md
JTAG_REG_BRIDGE -- requirements
Module: jtag_reg_bridge

Interface
REQ-001 Parameter ID_VALUE, default 32'h4B340001, constant returned by IDCODE.
REQ-002 Parameter TIMEOUT, default 255, bus cycles allowed before a pending access is abandoned.
REQ-003 tck  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 tdi  in  1  serial data from the virtual JTAG node.
REQ-006 tdo  out 1  serial data to the virtual JTAG node.
REQ-007 ir_in  in  3  current virtual instruction; ir_out  out 3  instruction-capture status.
REQ-008 vs_cdr, vs_sdr, vs_udr, vs_cir, vs_uir  in  1 each  virtual TAP state strobes; at most one high per cycle.
REQ-009 bus_addr  out 8; bus_wdata  out 16; bus_wr, bus_rd  out 1  register-bus request.
REQ-010 bus_ack  in 1; bus_rdata  in 16  register-bus completion and read data.

Function
REQ-011 Instructions: 0 BYPASS (1 bit), 1 IDCODE (32), 2 ADDR (8), 3 WRITE (16), 4 READ (17), 5 STATUS (8); codes 6-7 behave as BYPASS.
REQ-012 A 32-bit shift register SR is used; tdo SHALL equal SR[0] combinationally.
REQ-013 On vs_cdr SR SHALL load: BYPASS 0, IDCODE ID_VALUE, ADDR addr, WRITE wdata, READ {rd_valid, rd_hold}, STATUS {4'b0, timeout_err, overrun_err, rd_valid, busy}.
REQ-014 On vs_sdr SR SHALL shift right by one, LSB first, with tdi written to bit (length-1) of the current instruction.
REQ-015 On vs_udr: ADDR latches SR[7:0] into addr; WRITE latches SR[15:0] into wdata and issues a write; STATUS clears timeout_err/overrun_err where SR[3]/SR[2] is 1; other instructions take no action.
REQ-016 On vs_uir with ir_in=READ, a read of addr SHALL be issued and rd_valid cleared.
REQ-017 On vs_cir ir_out SHALL latch {timeout_err|overrun_err, rd_valid, busy}.
REQ-018 Bus FSM states: IDLE, WR_PEND, RD_PEND; busy = state != IDLE.
REQ-019 IDLE->WR_PEND on issued write; IDLE->RD_PEND on issued read; bus_wr/bus_rd asserted from the next cycle and held until exit.
REQ-020 bus_addr = addr and bus_wdata = wdata, stable while pending.
REQ-021 In WR_PEND/RD_PEND, bus_ack SHALL return to IDLE next cycle; RD_PEND also captures bus_rdata into rd_hold and sets rd_valid; addr increments by 1 modulo 256.
REQ-022 bus_ack in IDLE SHALL be ignored.
REQ-023 A cycle counter runs while pending; when it reaches TIMEOUT without ack, the FSM SHALL return to IDLE, set timeout_err, leave addr unchanged, and leave rd_valid clear.
REQ-024 A write or read issued while busy SHALL be dropped and set overrun_err; the pending access continues.
REQ-025 ack and timeout in the same cycle: ack wins.
REQ-026 An ADDR UDR while busy SHALL update addr only after the FSM returns to IDLE; the pending access completes on its original address.

Reset
REQ-027 rst SHALL force IDLE, SR=0, addr=0, wdata=0, rd_hold=0, rd_valid=0, both error flags 0, counter 0, ir_out=0, bus_wr=bus_rd=0.
REQ-028 rst during a pending access SHALL abandon it without setting any flag; a later bus_ack is ignored.

Structure
REQ-029 Instruction codes, per-instruction lengths, and FSM state encoding SHALL reside in shared package jtag_pkg.
REQ-030 The shift register with its capture/shift/length logic SHALL be sub-module jtag_dr_shifter; the bus FSM stays in the top level.

Verification
REQ-031 IDCODE: CDR then 32 SDR cycles -> tdo sequence equals 32'h4B340001 LSB first.
REQ-032 ADDR 8'h10, then WRITE 16'hBEEF UDR -> bus_wr high with addr 10/wdata BEEF; ack after 3 cycles -> bus_wr low, addr becomes 11.
REQ-033 READ UIR at addr 8'h20, ack with rdata 16'h1234 -> READ CDR shifts out 17'h11234, addr becomes 21.
REQ-034 WRITE with no ack -> after 255 pending cycles, bus_wr drops, STATUS reads 8'h08; STATUS UDR writing 8'h08 clears it to 0.
REQ-035 Second WRITE UDR while WR_PEND -> overrun_err set, single bus transaction observed, ir_out[2]=1 at next CIR.
REQ-036 rst mid RD_PEND then late bus_ack -> all outputs 0, rd_valid stays 0.
